// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port sequencer for a shared registered 32-bit ALU.
// Define ALU_ARBITER_OPCHECK_EN to trap illegal opcodes instead of forwarding them.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_cout_o,
  output logic        rsp_overflow_o,
  output logic        rsp_err_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_cout_i,
  input  logic        alu_overflow_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q;
  logic        last_q, id_q, err_q, zero_q, cout_q, ovf_q;
  logic        gnt, hs, bad_d;
  logic [3:0]  cnt_q, ctrl_q, op_d;
  logic [31:0] src1_q, src2_q, res_q, src1_d, src2_d;
  assign gnt          = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
  assign req0_ready_o = rst_n && state_q == IDLE && req0_valid_i && !gnt;
  assign req1_ready_o = rst_n && state_q == IDLE && req1_valid_i && gnt;
  assign hs           = req0_ready_o || req1_ready_o;
  assign src1_d       = gnt ? req1_src1_i : req0_src1_i;
  assign src2_d       = gnt ? req1_src2_i : req0_src2_i;
  assign op_d         = gnt ? req1_op_i : req0_op_i;
`ifdef ALU_ARBITER_OPCHECK_EN
  assign bad_d = !(op_d inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111});
`else
  assign bad_d = 1'b0;
`endif
  // An illegal op takes a one-edge pass through EXEC and reports zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          state_q <= EXEC;
          last_q  <= gnt;
          id_q    <= gnt;
          err_q   <= bad_d;
          cnt_q   <= bad_d ? 4'd1 : 4'(ALU_LAT + 1);
          if (!bad_d) begin
            src1_q <= src1_d;
            src2_q <= src2_d;
            ctrl_q <= op_d;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            res_q   <= err_q ? '0 : alu_result_i;
            zero_q  <= !err_q && alu_zero_i;
            cout_q  <= !err_q && alu_cout_i;
            ovf_q   <= !err_q && alu_overflow_i;
          end
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid_o    = state_q == RESP;
  assign rsp_id_o       = id_q;
  assign rsp_result_o   = res_q;
  assign rsp_zero_o     = zero_q;
  assign rsp_cout_o     = cout_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_err_o      = err_q;
  assign alu_src1_o     = src1_q;
  assign alu_src2_o     = src2_q;
  assign alu_ctrl_o     = ctrl_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against an arithmetic ALU model.
module tb_alu_arbiter;
  localparam int LAT = 1;
  logic clk = 1'b0, rst_n;
  logic req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
  logic [3:0] req0_op_i, req1_op_i, alu_ctrl_o;
  logic rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, rsp_cout_o, rsp_overflow_o, rsp_err_o;
  logic [31:0] rsp_result_o, alu_src1_o, alu_src2_o, alu_result_i;
  logic alu_zero_i, alu_cout_i, alu_overflow_i;
  int n_cmp = 0, n_fail = 0;

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_src1_i(req0_src1_i),
    .req0_src2_i(req0_src2_i), .req0_op_i(req0_op_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_src1_i(req1_src1_i),
    .req1_src2_i(req1_src2_i), .req1_op_i(req1_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_cout_o(rsp_cout_o),
    .rsp_overflow_o(rsp_overflow_o), .rsp_err_o(rsp_err_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_cout_i(alu_cout_i),
    .alu_overflow_i(alu_overflow_i)
  );

  always #5 clk = ~clk;

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
  endfunction

  // Packed as {overflow, cout, zero, result}
  function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b1100: r = ~(a | b);
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {v, c, (r == 32'd0), r};
  endfunction

  // Registered ALU stand-in; unknown codes keep the previous outputs
  always @(posedge clk)
    if (legal(alu_ctrl_o))
      {alu_overflow_i, alu_cout_i, alu_zero_i, alu_result_i} <= ref_alu(alu_ctrl_o, alu_src1_o, alu_src2_o);

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_op(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic id, output logic [34:0] f, output logic e, output int lat, output logic to);
    to = 1'b0; lat = 0; rsp_ready_i = 1'b1;
    @(negedge clk);
    if (p) begin req1_valid_i = 1'b1; req1_src1_i = a; req1_src2_i = b; req1_op_i = op; end
    else begin req0_valid_i = 1'b1; req0_src1_i = a; req0_src2_i = b; req0_op_i = op; end
    #1;
    for (int i = 0; i < 50 && !(p ? req1_ready_o : req0_ready_o); i++) begin @(negedge clk); #1; end
    if (!(p ? req1_ready_o : req0_ready_o)) to = 1'b1;
    @(posedge clk); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    while (!rsp_valid_o && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid_o) to = 1'b1;
    @(negedge clk);
    id = rsp_id_o; e = rsp_err_o;
    f = {rsp_overflow_o, rsp_cout_o, rsp_zero_o, rsp_result_o};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_src1_i = 32'h1; req0_src2_i = 32'h2; req0_op_i = 4'b0010;
    req1_valid_i = 1'b0; req1_src1_i = '0; req1_src2_i = '0; req1_op_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_o); end
    n_cmp++; if (rsp_id_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id_o); end
    n_cmp++; if (rsp_result_o !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result_o); end
    n_cmp++; if ({rsp_zero_o, rsp_cout_o, rsp_overflow_o, rsp_err_o} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {rsp_zero_o, rsp_cout_o, rsp_overflow_o, rsp_err_o}); end
    n_cmp++; if ({alu_src1_o, alu_src2_o} !== 64'd0) begin n_fail++; $display("FAIL reset_alu_src got %h/%h exp 0", alu_src1_o, alu_src2_o); end
    n_cmp++; if (alu_ctrl_o !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_ctrl got %b exp 0000", alu_ctrl_o); end
    n_cmp++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", {req0_ready_o, req1_ready_o}); end
    req0_valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [31:0] a, b, exp_r;
    int k, prev;
    a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; k = 0; prev = 0;
    @(negedge clk);
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_src1_i = a; req0_src2_i = b; req0_op_i = 4'b0000;
    req1_valid_i = 1'b1; req1_src1_i = a; req1_src2_i = b; req1_op_i = 4'b0001;
    for (int cyc = 0; cyc < 200 && k < 6; cyc++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        exp_r = k[0] ? 32'hFFF0_FFF0 : 32'hF000_F000;
        n_cmp++; if (rsp_id_o !== k[0]) begin n_fail++; $display("FAIL rr_id[%0d] got %b exp %b", k, rsp_id_o, k[0]); end
        n_cmp++; if (rsp_result_o !== exp_r) begin n_fail++; $display("FAIL rr_result[%0d] got %h exp %h", k, rsp_result_o, exp_r); end
        if (k > 0) begin
          n_cmp++; if (cyc - prev != LAT + 3) begin n_fail++; $display("FAIL rr_period[%0d] got %0d exp %0d", k, cyc - prev, LAT + 3); end
        end
        prev = cyc;
        k++;
      end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    n_cmp++; if (k != 6) begin n_fail++; $display("FAIL rr_count got %0d exp 6", k); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic id, e, to;
    logic [34:0] f;
    int lat;
    do_op(1'b0, 4'b0010, 32'd5, 32'd7, id, f, e, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b exp 0", to); end
    n_cmp++; if (lat != LAT + 1) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT + 1); end
    n_cmp++; if (f !== {3'b000, 32'd12}) begin n_fail++; $display("FAIL basic_result got %h exp %h", f, {3'b000, 32'd12}); end
    n_cmp++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id got %b exp 0", id); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", e); end
    n_cmp++; if (alu_ctrl_o !== 4'b0010) begin n_fail++; $display("FAIL basic_alu_ctrl got %b exp 0010", alu_ctrl_o); end
  endtask

  task automatic test_flags();
    logic id, e, to;
    logic [34:0] f;
    int lat;
    do_op(1'b1, 4'b0110, 32'd3, 32'd3, id, f, e, lat, to);
    n_cmp++; if ({to, id, f[32], f[31:0]} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin n_fail++;
      $display("FAIL sub_zero got to=%b id=%b z=%b r=%h exp to=0 id=1 z=1 r=0", to, id, f[32], f[31:0]); end
    do_op(1'b1, 4'b0111, 32'd2, 32'd9, id, f, e, lat, to);
    n_cmp++; if ({to, id, f[31:0]} !== {1'b0, 1'b1, 32'd1}) begin n_fail++;
      $display("FAIL slt got to=%b id=%b r=%h exp to=0 id=1 r=1", to, id, f[31:0]); end
    do_op(1'b0, 4'b0010, 32'h7FFF_FFFF, 32'd1, id, f, e, lat, to);
    n_cmp++; if ({to, f[34], f[31:0]} !== {1'b0, 1'b1, 32'h8000_0000}) begin n_fail++;
      $display("FAIL add_ovf got to=%b v=%b r=%h exp to=0 v=1 r=80000000", to, f[34], f[31:0]); end
  endtask

  task automatic test_random();
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [31:0] a, b;
    logic [34:0] f, exp_f;
    logic p, id, e, to;
    int lat;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    for (int n = 0; n < 24; n++) begin
      p = 1'($urandom_range(0, 1));
      op = ops[$urandom_range(0, 5)];
      a = $urandom; b = (n % 4 == 0) ? a : $urandom;
      exp_f = ref_alu(op, a, b);
      do_op(p, op, a, b, id, f, e, lat, to);
      n_cmp++; if ({to, id, e, f} !== {1'b0, p, 1'b0, exp_f} || lat != LAT + 1) begin n_fail++;
        $display("FAIL rand[%0d] op=%b got to=%b id=%b err=%b f=%h lat=%0d exp to=0 id=%b err=0 f=%h lat=%0d",
                 n, op, to, id, e, f, lat, p, exp_f, LAT + 1); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req0_valid_i = 1'b1; req0_src1_i = 32'd10; req0_src2_i = 32'd20; req0_op_i = 4'b0010;
    #1;
    n_cmp++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept0 got %b exp 1", req0_ready_o); end
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    w = 0;
    while (!rsp_valid_o && w < 20) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    req1_valid_i = 1'b1; req1_src1_i = 32'd9; req1_src2_i = 32'd4; req1_op_i = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({rsp_valid_o, rsp_id_o, rsp_result_o, req1_ready_o} !== {1'b1, 1'b0, 32'd30, 1'b0}) begin n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b id=%b r=%h rdy1=%b exp v=1 id=0 r=1e rdy1=0", i, rsp_valid_o, rsp_id_o, rsp_result_o, req1_ready_o); end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rsp_valid_o, req1_ready_o} !== 2'b01) begin n_fail++;
      $display("FAIL bp_next got v=%b rdy1=%b exp v=0 rdy1=1", rsp_valid_o, req1_ready_o); end
    @(posedge clk); #1;
    req1_valid_i = 1'b0;
    w = 0;
    while (!rsp_valid_o && w < 20) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    n_cmp++; if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'b1, 32'd5}) begin n_fail++;
      $display("FAIL bp_second got v=%b id=%b r=%h exp v=1 id=1 r=5", rsp_valid_o, rsp_id_o, rsp_result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_op();
    logic id, e, to;
    logic [34:0] f;
    int lat;
    do_op(1'b0, 4'b0000, 32'h0F, 32'hFF, id, f, e, lat, to);
    do_op(1'b0, 4'b1111, 32'h123, 32'h456, id, f, e, lat, to);
`ifdef ALU_ARBITER_OPCHECK_EN
    n_cmp++; if ({to, e, f} !== {1'b0, 1'b1, 35'd0} || lat != 1) begin n_fail++;
      $display("FAIL badop_rsp got to=%b err=%b f=%h lat=%0d exp to=0 err=1 f=0 lat=1", to, e, f, lat); end
    n_cmp++; if ({alu_ctrl_o, alu_src1_o} !== {4'b0000, 32'h0F}) begin n_fail++;
      $display("FAIL badop_alu got ctrl=%b src1=%h exp ctrl=0000 src1=f", alu_ctrl_o, alu_src1_o); end
`else
    n_cmp++; if ({to, e, f[31:0]} !== {1'b0, 1'b0, 32'h0F} || lat != LAT + 1) begin n_fail++;
      $display("FAIL badop_rsp got to=%b err=%b r=%h lat=%0d exp to=0 err=0 r=f lat=%0d", to, e, f[31:0], lat, LAT + 1); end
    n_cmp++; if ({alu_ctrl_o, alu_src1_o} !== {4'b1111, 32'h123}) begin n_fail++;
      $display("FAIL badop_alu got ctrl=%b src1=%h exp ctrl=1111 src1=123", alu_ctrl_o, alu_src1_o); end
`endif
    do_op(1'b1, 4'b1100, 32'h0, 32'h0, id, f, e, lat, to);
    n_cmp++; if ({to, id, e, f[31:0]} !== {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin n_fail++;
      $display("FAIL badop_after got to=%b id=%b err=%b r=%h exp to=0 id=1 err=0 r=ffffffff", to, id, e, f[31:0]); end
  endtask

  task automatic test_reset_mid();
    logic id, e, to;
    logic [34:0] f;
    int lat, seen;
    seen = 0;
    do_op(1'b1, 4'b0001, 32'h55, 32'hAA, id, f, e, lat, to);
    @(negedge clk);
    req0_valid_i = 1'b1; req0_src1_i = 32'd1; req0_src2_i = 32'd2; req0_op_i = 4'b0010;
    #1;
    n_cmp++; if (req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got %b exp 1", req0_ready_o); end
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b0, 1'b0, 32'd0}) begin n_fail++;
      $display("FAIL rmid_rsp got v=%b id=%b r=%h exp 0/0/0", rsp_valid_o, rsp_id_o, rsp_result_o); end
    n_cmp++; if ({alu_src1_o, alu_ctrl_o} !== {32'd0, 4'b0000}) begin n_fail++;
      $display("FAIL rmid_alu got src1=%h ctrl=%b exp 0/0000", alu_src1_o, alu_ctrl_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid_o) seen++; end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_rsp got %0d exp 0", seen); end
    do_op(1'b1, 4'b0010, 32'd100, 32'd23, id, f, e, lat, to);
    n_cmp++; if ({to, id, f[31:0]} !== {1'b0, 1'b1, 32'd123} || lat != LAT + 1) begin n_fail++;
      $display("FAIL rmid_after got to=%b id=%b r=%h lat=%0d exp to=0 id=1 r=7b lat=%0d", to, id, f[31:0], lat, LAT + 1); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_flags();
    test_random();
    test_backpressure();
    test_bad_op();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
